// File: rtl/shift_deserializer.sv
// Serial-to-parallel receiver: assembles WIDTH bits (MSB- or LSB-first) into a word on a valid/ready port.
// Optional even-parity trailer bit and par_err flag enabled by defining DESER_PARITY_EN.
module shift_deserializer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             ser_valid,
  input  logic             ser_data,
  output logic             ser_ready,
  input  logic             dir,
  output logic [WIDTH-1:0] par_data,
  output logic             par_valid,
  input  logic             par_ready,
  output logic             par_err
);

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

`ifdef DESER_PARITY_EN
  localparam bit PARITY = 1'b1;
  localparam int LAST   = WIDTH;
`else
  localparam bit PARITY = 1'b0;
  localparam int LAST   = WIDTH - 1;
`endif
  // cnt value seen on the final accept of a frame (compared before increment to avoid overflow)
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LAST);

  state_t             state, state_nxt;
  logic               live;
  logic               dir_q;
  logic               shift_dir;
  logic               accept;
  logic               last_bit;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   sreg;
  logic [WIDTH-1:0]   sreg_nxt;

  assign ser_ready = live && (state != HOLD);
  assign accept    = ser_valid && ser_ready;
  assign last_bit  = (state == SHIFT) && (cnt == LAST_CNT);
  assign shift_dir = (state == IDLE) ? dir : dir_q;
  assign sreg_nxt  = shift_dir ? {ser_data, sreg[WIDTH-1:1]} : {sreg[WIDTH-2:0], ser_data};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SHIFT;
      SHIFT:   if (accept && last_bit) state_nxt = HOLD;
      HOLD:    if (par_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (clr) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live      <= 1'b0;
      dir_q     <= 1'b0;
      cnt       <= '0;
      sreg      <= '0;
      par_data  <= '0;
      par_valid <= 1'b0;
    end else begin
      live <= 1'b1;
      if (clr) begin
        cnt       <= '0;
        sreg      <= '0;
        par_valid <= 1'b0;
      end else if (state == HOLD) begin
        if (par_ready) par_valid <= 1'b0;
      end else if (accept) begin
        if (state == IDLE) dir_q <= dir;
        if (last_bit) begin
          cnt       <= '0;
          par_valid <= 1'b1;
          // with parity the final bit is the trailer, so the word is already complete in sreg
          par_data  <= PARITY ? sreg : sreg_nxt;
          if (!PARITY) sreg <= sreg_nxt;
        end else begin
          cnt  <= (state == IDLE) ? CNT_W'(1) : cnt + CNT_W'(1);
          sreg <= sreg_nxt;
        end
      end
    end
  end

`ifdef DESER_PARITY_EN
  logic err_q;
  assign par_err = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             err_q <= 1'b0;
    else if (clr)                           err_q <= 1'b0;
    else if (state == HOLD && par_ready)    err_q <= 1'b0;
    else if (accept && last_bit)            err_q <= (^sreg) ^ ser_data;
  end
`else
  assign par_err = 1'b0;
`endif

endmodule
